// File: rtl/decode_stage_hs.sv
// RISC-V ID stage with ID/EX register and a valid/ready handshake toward EX.
// Covers decode, regfile, immediate generation, load-use stall and trap classification.
module decode_stage_hs #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_inst,
  input  logic            flush,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_alt,
  output logic [3:0]      ex_opclass,
  output logic            ex_use_rs1,
  output logic            ex_use_rs2,
  output logic            ex_regwrite,
  output logic            ex_trap,
  output logic [1:0]      ex_trap_cause
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                         OP_SYSTEM = 7'b1110011, OP_FENCE = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            alt;
    logic [3:0]      opclass;
    logic            use_rs1;
    logic            use_rs2;
    logic            regwrite;
    logic            trap;
    logic [1:0]      cause;
  } ex_pkt_t;

  function automatic logic in_range(input logic [4:0] r);
    return 32'(r) < NREG;
  endfunction

  logic [XLEN-1:0] rf_q [NREG];
  logic            wb_we;
  logic [XLEN-1:0] rd1, rd2;
  ex_pkt_t         dec, ex_q;
  logic            ex_valid_q, hazard;

  assign wb_we = wb_regwrite && (wb_rd != 5'd0) && in_range(wb_rd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_rd[RW-1:0]] <= wb_data;
    end
  end

  // Out-of-range indices read 0; the decode flags them illegal anyway.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (id_inst[19:15] != 5'd0 && in_range(id_inst[19:15])) begin
      if (WB_BYPASS != 0 && wb_we && wb_rd == id_inst[19:15]) rd1 = wb_data;
      else rd1 = rf_q[id_inst[15+RW-1:15]];
    end
    if (id_inst[24:20] != 5'd0 && in_range(id_inst[24:20])) begin
      if (WB_BYPASS != 0 && wb_we && wb_rd == id_inst[24:20]) rd2 = wb_data;
      else rd2 = rf_q[id_inst[20+RW-1:20]];
    end
  end

  always_comb begin
    logic wr, ill;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = XLEN'($signed(id_inst[31:20]));
    imm_s = XLEN'($signed({id_inst[31:25], id_inst[11:7]}));
    imm_b = XLEN'($signed({id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0}));
    imm_u = XLEN'($signed({id_inst[31:12], 12'b0}));
    imm_j = XLEN'($signed({id_inst[31], id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0}));
    dec          = '0;
    dec.pc       = id_pc;
    dec.rs1_data = rd1;
    dec.rs2_data = rd2;
    dec.rs1      = id_inst[19:15];
    dec.rs2      = id_inst[24:20];
    dec.rd       = id_inst[11:7];
    dec.funct3   = id_inst[14:12];
    dec.alt      = id_inst[30];
    wr  = 1'b0;
    ill = (id_inst[1:0] != 2'b11);
    case (id_inst[6:0])
      OP_LUI:    begin dec.opclass = 4'd0; dec.imm = imm_u; wr = 1'b1; end
      OP_AUIPC:  begin dec.opclass = 4'd1; dec.imm = imm_u; wr = 1'b1; end
      OP_JAL:    begin dec.opclass = 4'd2; dec.imm = imm_j; wr = 1'b1; end
      OP_JALR:   begin dec.opclass = 4'd3; dec.imm = imm_i; wr = 1'b1; dec.use_rs1 = 1'b1; end
      OP_BRANCH: begin dec.opclass = 4'd4; dec.imm = imm_b; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
      OP_LOAD:   begin dec.opclass = 4'd5; dec.imm = imm_i; wr = 1'b1; dec.use_rs1 = 1'b1; end
      OP_STORE:  begin dec.opclass = 4'd6; dec.imm = imm_s; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
      OP_IMM:    begin dec.opclass = 4'd7; dec.imm = imm_i; wr = 1'b1; dec.use_rs1 = 1'b1; end
      OP_OP:     begin dec.opclass = 4'd8; wr = 1'b1; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; end
      OP_SYSTEM: begin
        dec.opclass = 4'd9;
        dec.trap    = 1'b1;
        if (id_inst == 32'h0000_0073)      dec.cause = 2'd1;
        else if (id_inst == 32'h0010_0073) dec.cause = 2'd2;
        else ill = 1'b1;
      end
      OP_FENCE:  begin dec.opclass = 4'd10; dec.imm = imm_i; end
      default:   ill = 1'b1;
    endcase
    if ((dec.use_rs1 && !in_range(dec.rs1)) || (dec.use_rs2 && !in_range(dec.rs2)) ||
        (wr && !in_range(dec.rd)))
      ill = 1'b1;
    dec.regwrite = wr && (dec.rd != 5'd0);
    if (ill) begin
      dec.opclass  = 4'd15;
      dec.trap     = 1'b1;
      dec.cause    = 2'd0;
      dec.imm      = '0;
      dec.use_rs1  = 1'b0;
      dec.use_rs2  = 1'b0;
      dec.regwrite = 1'b0;
    end
  end

  assign hazard = ex_valid_q && (ex_q.opclass == 4'd5) && (ex_q.rd != 5'd0) &&
                  ((dec.use_rs1 && dec.rs1 == ex_q.rd) || (dec.use_rs2 && dec.rs2 == ex_q.rd));

  assign id_ready = !flush && (!ex_valid_q || ex_ready) && !hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (ex_valid_q && !ex_ready) begin
      // Stalled operands must track retiring writebacks or they go stale.
      if (wb_regwrite && ex_q.use_rs1 && ex_q.rs1 != 5'd0 && wb_rd == ex_q.rs1)
        ex_q.rs1_data <= wb_data;
      if (wb_regwrite && ex_q.use_rs2 && ex_q.rs2 != 5'd0 && wb_rd == ex_q.rs2)
        ex_q.rs2_data <= wb_data;
    end else if (id_valid && id_ready) begin
      ex_valid_q <= 1'b1;
      ex_q       <= dec;
    end else begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_funct3     = ex_q.funct3;
  assign ex_alt        = ex_q.alt;
  assign ex_opclass    = ex_q.opclass;
  assign ex_use_rs1    = ex_q.use_rs1;
  assign ex_use_rs2    = ex_q.use_rs2;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_trap       = ex_q.trap;
  assign ex_trap_cause = ex_q.cause;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench: default core, an RV32E instance and a no-bypass instance share stimulus.
module tb_decode_stage_hs;
  logic        clock = 1'b0, reset = 1'b1;
  logic        id_valid = 1'b0, flush = 1'b0, wb_regwrite = 1'b0, ex_ready = 1'b1;
  logic [31:0] id_pc = '0, id_inst = '0, wb_data = '0;
  logic [4:0]  wb_rd = '0;
  int checks = 0, errors = 0;

  always #5 clock = ~clock;

  logic        id_ready, ex_valid, ex_alt, ex_use_rs1, ex_use_rs2, ex_regwrite, ex_trap;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_opclass;
  logic [1:0]  ex_trap_cause;

  logic        e_id_ready, e_ex_valid, e_ex_alt, e_ex_use_rs1, e_ex_use_rs2, e_ex_regwrite, e_ex_trap;
  logic [31:0] e_ex_pc, e_ex_rs1_data, e_ex_rs2_data, e_ex_imm;
  logic [4:0]  e_ex_rs1, e_ex_rs2, e_ex_rd;
  logic [2:0]  e_ex_funct3;
  logic [3:0]  e_ex_opclass;
  logic [1:0]  e_ex_trap_cause;

  logic        n_id_ready, n_ex_valid, n_ex_alt, n_ex_use_rs1, n_ex_use_rs2, n_ex_regwrite, n_ex_trap;
  logic [31:0] n_ex_pc, n_ex_rs1_data, n_ex_rs2_data, n_ex_imm;
  logic [4:0]  n_ex_rs1, n_ex_rs2, n_ex_rd;
  logic [2:0]  n_ex_funct3;
  logic [3:0]  n_ex_opclass;
  logic [1:0]  n_ex_trap_cause;

  decode_stage_hs u_dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_inst(id_inst), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_alt(ex_alt), .ex_opclass(ex_opclass), .ex_use_rs1(ex_use_rs1),
    .ex_use_rs2(ex_use_rs2), .ex_regwrite(ex_regwrite), .ex_trap(ex_trap),
    .ex_trap_cause(ex_trap_cause));

  decode_stage_hs #(.NREG(16)) u_e (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(e_id_ready), .id_pc(id_pc),
    .id_inst(id_inst), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(e_ex_valid), .ex_pc(e_ex_pc), .ex_rs1_data(e_ex_rs1_data),
    .ex_rs2_data(e_ex_rs2_data), .ex_imm(e_ex_imm), .ex_rs1(e_ex_rs1), .ex_rs2(e_ex_rs2),
    .ex_rd(e_ex_rd), .ex_funct3(e_ex_funct3), .ex_alt(e_ex_alt), .ex_opclass(e_ex_opclass),
    .ex_use_rs1(e_ex_use_rs1), .ex_use_rs2(e_ex_use_rs2), .ex_regwrite(e_ex_regwrite),
    .ex_trap(e_ex_trap), .ex_trap_cause(e_ex_trap_cause));

  decode_stage_hs #(.WB_BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(n_id_ready), .id_pc(id_pc),
    .id_inst(id_inst), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(n_ex_valid), .ex_pc(n_ex_pc), .ex_rs1_data(n_ex_rs1_data),
    .ex_rs2_data(n_ex_rs2_data), .ex_imm(n_ex_imm), .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2),
    .ex_rd(n_ex_rd), .ex_funct3(n_ex_funct3), .ex_alt(n_ex_alt), .ex_opclass(n_ex_opclass),
    .ex_use_rs1(n_ex_use_rs1), .ex_use_rs2(n_ex_use_rs2), .ex_regwrite(n_ex_regwrite),
    .ex_trap(n_ex_trap), .ex_trap_cause(n_ex_trap_cause));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
    id_valid = 1'b1; id_pc = pc; id_inst = inst;
    step();
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_opclass", {28'd0, ex_opclass}, 32'd0);
    @(negedge clock); reset = 1'b0; #1;
    chk("rst_ready", {31'd0, id_ready}, 32'd1);

    // ADDI x1,x0,5
    issue(32'h100, 32'h0050_0093);
    chk("addi_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_opclass", {28'd0, ex_opclass}, 32'd7);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_rd", {27'd0, ex_rd}, 32'd1);
    chk("addi_regwrite", {31'd0, ex_regwrite}, 32'd1);
    chk("addi_pc", ex_pc, 32'h100);

    // LW x2,0(x1) with WB x1=5 in the same cycle (bypassed read)
    wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    id_pc = 32'h104; id_inst = 32'h0000_A103; #1;
    chk("lw_ready", {31'd0, id_ready}, 32'd1);
    step();
    wb_regwrite = 1'b0;
    chk("lw_opclass", {28'd0, ex_opclass}, 32'd5);
    chk("lw_bypass_rs1", ex_rs1_data, 32'd5);
    chk("lw_nobypass_rs1", n_ex_rs1_data, 32'd0);

    // ADD x3,x2,x1 right behind the load: one bubble
    id_pc = 32'h108; id_inst = 32'h0011_01B3; #1;
    chk("hz_ready0", {31'd0, id_ready}, 32'd0);
    step();
    chk("hz_bubble", {31'd0, ex_valid}, 32'd0);
    chk("hz_ready1", {31'd0, id_ready}, 32'd1);
    step();
    chk("hz_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("hz_add_pc", ex_pc, 32'h108);
    chk("hz_add_uses", {30'd0, ex_use_rs1, ex_use_rs2}, 32'd3);
    chk("hz_add_rs2data", ex_rs2_data, 32'd5);

    // ADD x3,x1,x2 then 3-cycle stall with WB x1=0xDEAD
    issue(32'h10C, 32'h0020_81B3);
    chk("hold_rs1_pre", ex_rs1_data, 32'd5);
    ex_ready = 1'b0; id_pc = 32'h110; id_inst = 32'h0050_0093;
    wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD; #1;
    chk("hold_ready", {31'd0, id_ready}, 32'd0);
    step();
    wb_regwrite = 1'b0;
    chk("hold_refresh", ex_rs1_data, 32'hDEAD);
    chk("hold_pc1", ex_pc, 32'h10C);
    step(); step();
    chk("hold_valid3", {31'd0, ex_valid}, 32'd1);
    chk("hold_pc3", ex_pc, 32'h10C);
    chk("hold_rs1_3", ex_rs1_data, 32'hDEAD);
    chk("hold_rd3", {27'd0, ex_rd}, 32'd3);
    chk("hold_ready3", {31'd0, id_ready}, 32'd0);
    ex_ready = 1'b1;
    step();
    chk("release_pc", ex_pc, 32'h110);

    // flush with id_valid
    flush = 1'b1; id_pc = 32'h114; id_inst = 32'h0050_0093; #1;
    chk("flush_ready", {31'd0, id_ready}, 32'd0);
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;
    step();
    chk("reissue_valid", {31'd0, ex_valid}, 32'd1);
    chk("reissue_pc", ex_pc, 32'h114);

    // ADD x17,x1,x2: legal on 32 regs, illegal on 16
    issue(32'h118, 32'h0020_88B3);
    chk("e_x17_opclass", {28'd0, e_ex_opclass}, 32'd15);
    chk("e_x17_trap", {30'd0, e_ex_trap, 1'b0} | {30'd0, e_ex_trap_cause}, 32'd2);
    chk("e_x17_regwrite", {31'd0, e_ex_regwrite}, 32'd0);
    chk("x17_opclass", {28'd0, ex_opclass}, 32'd8);
    chk("x17_trap", {31'd0, ex_trap}, 32'd0);

    issue(32'h11C, 32'h0000_0073);
    chk("ecall", {26'd0, ex_opclass, ex_trap, ex_regwrite}, {26'd0, 4'd9, 1'b1, 1'b0});
    chk("ecall_cause", {30'd0, ex_trap_cause}, 32'd1);
    issue(32'h120, 32'h0010_0073);
    chk("ebreak_cause", {30'd0, ex_trap_cause}, 32'd2);
    issue(32'h124, 32'h0000_0000);
    chk("ill_low", {27'd0, ex_opclass, ex_trap}, {27'd0, 4'd15, 1'b1});
    issue(32'h128, 32'h3000_2573);
    chk("ill_csr", {26'd0, ex_opclass, ex_trap, ex_use_rs1}, {26'd0, 4'd15, 1'b1, 1'b0});

    // immediate formats
    issue(32'h12C, 32'h0020_A423);
    chk("sw", {26'd0, ex_opclass, ex_use_rs2, ex_regwrite}, {26'd0, 4'd6, 1'b1, 1'b0});
    chk("sw_imm", ex_imm, 32'd8);
    issue(32'h130, 32'hFE00_0EE3);
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
    issue(32'h134, 32'h1234_52B7);
    chk("lui_imm", ex_imm, 32'h1234_5000);
    issue(32'h138, 32'h0080_00EF);
    chk("jal", {28'd0, ex_opclass}, 32'd2);
    chk("jal_imm", ex_imm, 32'd8);

    // WB x5 during ADDI x6,x5,0 decode
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    issue(32'h13C, 32'h0002_8313);
    wb_regwrite = 1'b0;
    chk("bypass_on", ex_rs1_data, 32'h1234);
    chk("bypass_off", n_ex_rs1_data, 32'h0);
    step();
    chk("bypass_off_later", n_ex_rs1_data, 32'h1234);

    // writes to x0 are dropped
    wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    issue(32'h140, 32'h0000_0313);
    wb_regwrite = 1'b0;
    chk("x0_same", ex_rs1_data, 32'd0);
    step();
    chk("x0_later", ex_rs1_data, 32'd0);

    // async reset while holding
    ex_ready = 1'b0;
    issue(32'h144, 32'h0050_0093);
    step();
    chk("prereset_valid", {31'd0, ex_valid}, 32'd1);
    @(negedge clock); reset = 1'b1; #1;
    chk("midreset_valid", {31'd0, ex_valid}, 32'd0);
    chk("midreset_pc", ex_pc, 32'd0);
    id_valid = 1'b0;
    @(negedge clock); reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
Parametrised ID stage with ID/EX pipeline register for the RISC-V core: control decode, register file, immediate generation and an output register. Adds a valid/ready handshake in place of bubble-on-stall; a stalled instruction is held, not zeroed. Also adds internal load-use hazard detection, trap classification, RV32E register-count support and WB-to-hold-register refresh. Sits between fetch (upstream) and execute (downstream).

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN
NREG, 32, architectural register count (32 or 16); index >= NREG is illegal
WB_BYPASS, 1, 1 = same-cycle WB write forwarded to regfile reads; 0 = read returns pre-write value

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-high
id_valid  in  1  fetch presents instruction
id_ready  out  1  stage accepts instruction this cycle
id_pc  in  XLEN  instruction PC
id_inst  in  32  instruction word
flush  in  1  kill ID/EX contents (branch/trap redirect)
wb_regwrite  in  1  writeback enable
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback data
ex_ready  in  1  execute accepts ex_* this cycle
ex_valid  out  1  ex_* payload valid
ex_pc  out  XLEN  registered PC
ex_rs1_data, ex_rs2_data  out  XLEN  operand values
ex_imm  out  XLEN  sign-extended immediate
ex_rs1, ex_rs2, ex_rd  out  5  register indices
ex_funct3  out  3  inst[14:12]
ex_alt  out  1  inst[30] (SUB/SRA select)
ex_opclass  out  4  0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 OP-IMM,8 OP,9 SYSTEM,10 FENCE,15 illegal
ex_use_rs1, ex_use_rs2  out  1  operand used
ex_regwrite  out  1  writes rd
ex_trap  out  1  trapping instruction
ex_trap_cause  out  2  0 illegal, 1 ECALL, 2 EBREAK

Behaviour:
- Reset (async): all ex_* outputs 0; regfile cleared to 0. id_ready = 1 after reset when flush = 0.
- Regfile: NREG x XLEN, x0 reads 0. Write at posedge when wb_regwrite && wb_rd != 0 && wb_rd < NREG. Reads are combinational on id_inst[19:15]/[24:20]; WB_BYPASS per parameter.
- Decode of the held instruction:
  - use_rs1 for JALR/BRANCH/LOAD/STORE/OP-IMM/OP.
  - use_rs2 for BRANCH/STORE/OP.
  - regwrite for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP with rd != 0.
  - Immediates use I/S/B/U/J formats; 0 for OP/SYSTEM.
- Illegal: inst[1:0] != 2'b11, unknown opcode, CSR/other SYSTEM, or used rs1/rs2/rd index >= NREG. Result is opclass 15, trap 1, cause 0, regwrite/use flags 0.
- ECALL 0x00000073: opclass 9, trap, cause 1. EBREAK 0x00100073: opclass 9, trap, cause 2.
- hazard = ex_valid && ex_opclass == 5 && ex_rd != 0 && ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd)), evaluated on the incoming instruction.
- id_ready = !flush && (!ex_valid || ex_ready) && !hazard (combinational).
- Register update, in priority order each posedge:
  1. flush: ex_valid <= 0; payload don't-care.
  2. ex_valid && !ex_ready: hold all outputs.
  3. id_valid && id_ready: capture decode, ex_valid <= 1.
  4. Otherwise ex_valid <= 0 (bubble, including on hazard).
- Latency: 1 cycle from accepted instruction to ex_valid.
- Hold refresh: while holding, a WB write with wb_rd == ex_rs1 (nonzero, ex_use_rs1) replaces ex_rs1_data with wb_data; same for rs2.
- Hazard and hold: hazard causes exactly one bubble once the load leaves EX. While the load is held, id_ready stays 0.
- Flush and id_valid in the same cycle: instruction not accepted (id_ready = 0), ex_valid = 0 next cycle.
- Reset mid-hold: outputs cleared immediately.

Test Plan:
- ADDI x1,x0,5 (0x00500093), pc 0x100, ex_ready = 1 -> next cycle ex_valid = 1, opclass 7, imm 5, rd 1, regwrite 1, pc 0x100.
- LW x2,0(x1) then ADD x3,x2,x1 back-to-back -> ADD: id_ready = 0 for one cycle, one bubble (ex_valid = 0), then ADD issued with use_rs1/use_rs2 = 1.
- ex_ready = 0 for 3 cycles with ADD x3,x1,x2 held; WB writes x1 = 0xDEAD -> outputs stable, ex_rs1_data becomes 0xDEAD, id_ready = 0.
- flush asserted with id_valid = 1 -> id_ready = 0, ex_valid = 0 next cycle, instruction re-presentable.
- NREG = 16: ADD x17,x1,x2 -> opclass 15, trap 1, cause 0, regwrite 0. ECALL -> cause 1; EBREAK -> cause 2.
- WB writes x5 = 0x1234 in the same cycle ADDI x6,x5,0 is decoded -> ex_rs1_data 0x1234 if WB_BYPASS = 1, old value if WB_BYPASS = 0. Any write to x0 leaves x0 reading 0.
